// File: rtl/wddl_dec_reg.sv
// wddl_dec_reg: receive-side decoder/register for a WDDL dual-rail bus.
// Watches the precharge/evaluate protocol on WIDTH p/n pairs, captures the
// single-rail word when every pair has resolved, and hands it downstream
// over a valid/ready handshake with sticky protocol-error flags.
// Optional feature macro: WDDL_DEC_LAT_EN adds an evaluate-to-complete
// latency counter and the lat_out port.
module wddl_dec_reg #(
  parameter int WIDTH = 8,
  parameter int LAT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             eval_in,
  input  logic [WIDTH-1:0] d_p_in,
  input  logic [WIDTH-1:0] d_n_in,
  input  logic             rdy_in,
  input  logic             err_clr_in,
  output logic [WIDTH-1:0] d_out,
  output logic             vld_out,
  output logic [2:0]       err_code_out
`ifdef WDDL_DEC_LAT_EN
  ,
  output logic [LAT_W-1:0] lat_out
`endif
);

  typedef enum logic [1:0] {
    ST_PRECH = 2'd0,
    ST_EVAL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Every pair at 00: the bus is fully precharged.
  function automatic logic f_all_pre(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n);
    return ~|(p | n);
  endfunction

  // Every pair complementary: evaluation has completed on all bits.
  function automatic logic f_all_done(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n);
    return &(p ^ n);
  endfunction

  // Any pair at 11: an illegal dual-rail code.
  function automatic logic f_any_ill(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n);
    return |(p & n);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_eval_q;
  logic             r_pre_ok;
  logic             w_pre_ok_nxt;
  logic [WIDTH-1:0] r_d;
  logic             r_vld;
  logic [2:0]       r_err;
  logic             w_all_pre;
  logic             w_all_done;
  logic             w_any_ill;
  logic             w_eval_rise;
  logic             w_eval_act;
  logic             w_capture;
  logic             w_xfer;
  logic [2:0]       w_err_set;
`ifdef WDDL_DEC_LAT_EN
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] w_lat_base;
  logic [LAT_W-1:0] w_lat_nxt;
`endif

  assign w_all_pre   = f_all_pre(d_p_in, d_n_in);
  assign w_all_done  = f_all_done(d_p_in, d_n_in);
  assign w_any_ill   = f_any_ill(d_p_in, d_n_in);
  assign w_eval_rise = eval_in & ~r_eval_q;

  // Next-state and control decode; the rising-edge sample that opens a
  // qualified window is judged by the evaluate rules in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_pre_ok_nxt = r_pre_ok;
    w_eval_act   = 1'b0;
    w_capture    = 1'b0;
    w_xfer       = 1'b0;
    w_err_set    = 3'b000;
`ifdef WDDL_DEC_LAT_EN
    w_lat_base   = r_lat_cnt;
    w_lat_nxt    = r_lat_cnt;
`endif
    w_err_set[0] = w_any_ill;

    case (r_state)
      ST_PRECH: begin
        if (w_eval_rise) begin
          if (r_pre_ok) begin
            w_eval_act = 1'b1;
`ifdef WDDL_DEC_LAT_EN
            w_lat_base = {LAT_W{1'b0}};
`endif
          end else begin
            // Window without a clean precharge: flag it and ignore it.
            w_err_set[2] = 1'b1;
          end
        end else if (!eval_in && w_all_pre) begin
          w_pre_ok_nxt = 1'b1;
        end else begin
          w_pre_ok_nxt = r_pre_ok;
        end
      end
      ST_EVAL: begin
        w_eval_act = 1'b1;
      end
      ST_HOLD: begin
        if (r_vld && rdy_in) begin
          w_xfer      = 1'b1;
          w_state_nxt = ST_PRECH;
        end else begin
          w_state_nxt = ST_HOLD;
        end
        if (w_eval_rise) begin
          // A token arriving while the word is still held is dropped; the
          // precharge it consumed no longer qualifies a later window.
          w_err_set[2] = 1'b1;
          w_pre_ok_nxt = 1'b0;
        end else if (!eval_in && w_all_pre) begin
          w_pre_ok_nxt = 1'b1;
        end else begin
          w_pre_ok_nxt = r_pre_ok;
        end
      end
      default: begin
        w_state_nxt  = ST_PRECH;
        w_pre_ok_nxt = 1'b0;
      end
    endcase

    if (w_eval_act) begin
      w_pre_ok_nxt = 1'b0;
      if (w_any_ill) begin
        w_state_nxt = ST_PRECH;
      end else if (!eval_in) begin
        w_err_set[1] = 1'b1;
        w_state_nxt  = ST_PRECH;
      end else if (w_all_done) begin
        w_capture   = 1'b1;
        w_state_nxt = ST_HOLD;
`ifdef WDDL_DEC_LAT_EN
        w_lat_nxt   = w_lat_base;
`endif
      end else begin
        w_state_nxt = ST_EVAL;
`ifdef WDDL_DEC_LAT_EN
        w_lat_nxt   = (&w_lat_base) ? w_lat_base
                                    : w_lat_base + {{(LAT_W-1){1'b0}}, 1'b1};
`endif
      end
    end else begin
      w_eval_act = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_PRECH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase history, precharge qualifier, captured word, handshake and errors.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_eval_q <= 1'b0;
      r_pre_ok <= 1'b0;
      r_d      <= {WIDTH{1'b0}};
      r_vld    <= 1'b0;
      r_err    <= 3'b000;
    end else begin
      r_eval_q <= eval_in;
      r_pre_ok <= w_pre_ok_nxt;
      if (w_capture) begin
        r_d   <= d_p_in;
        r_vld <= 1'b1;
      end else if (w_xfer) begin
        r_vld <= 1'b0;
      end
      // A new set beats a same-cycle clear for that bit only.
      r_err <= (err_clr_in ? 3'b000 : r_err) | w_err_set;
    end
  end

`ifdef WDDL_DEC_LAT_EN
  // Latency counter and the count latched at each capture.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_lat_cnt <= {LAT_W{1'b0}};
      r_lat     <= {LAT_W{1'b0}};
    end else begin
      r_lat_cnt <= w_lat_nxt;
      if (w_capture) begin
        r_lat <= w_lat_nxt;
      end
    end
  end

  assign lat_out = r_lat;
`endif

  assign d_out        = r_d;
  assign vld_out      = r_vld;
  assign err_code_out = r_err;

endmodule
